// File: rtl/uart_tx.sv
// Byte-stream UART transmitter: valid/ready byte input, serialised as
// start + 8 data (LSB first) + optional parity + 1 or 2 stop bits.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int BW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            tx_q, tx_d;
    logic            bit_end;
    logic            parity;

    assign bit_end  = (baud_q == BAUD_LAST);
    assign parity   = (^data_q) ^ (PARITY_ODD != 0);
    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign tx       = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the level for the bit that starts after this edge, so tx stays a pure flop output
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    data_d  = tx_data;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    tx_d    = data_q[0];
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            tx_d    = parity;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, even parity, odd parity, 2 stop bits)
// checked every cycle against a frame-level model, plus directed literal checks.
module tb_uart_tx;

    localparam int C = 4;
    localparam int N = 4;

    function automatic int pen(int i); return (i == 1 || i == 2) ? 1 : 0; endfunction
    function automatic int pod(int i); return (i == 2) ? 1 : 0; endfunction
    function automatic int sb(int i);  return (i == 3) ? 2 : 1; endfunction
    function automatic int flen(int i); return 9 + pen(i) + sb(i); endfunction

    // Level of frame bit j for byte b on instance i
    function automatic logic fbit(int i, logic [7:0] b, int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (pen(i) == 1 && j == 9) return (($countones(b) + pod(i)) % 2) == 1;
        return 1'b1;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data  [N];
    logic       valid [N];
    logic       tx    [N];
    logic       ready [N];
    logic       busy  [N];

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx #(
            .CLKS_PER_BIT(C),
            .PARITY_EN   (pen(g)),
            .PARITY_ODD  (pod(g)),
            .STOP_BITS   (sb(g))
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .tx_data (data[g]),
            .tx_valid(valid[g]),
            .tx_ready(ready[g]),
            .tx      (tx[g]),
            .busy    (busy[g])
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a frame is the accept time plus the byte; levels follow by arithmetic
    logic       act  [N];
    time        st   [N];
    logic [7:0] mb   [N];
    logic       mrdy [N];

    initial begin
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; mrdy[i] = 1'b1; st[i] = 0; mb[i] = '0;
            data[i] = '0; valid[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) act[i] = 1'b0;
            else if (valid[i] && mrdy[i]) begin
                act[i] = 1'b1; st[i] = $time; mb[i] = data[i];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                int   k;
                logic et, er;
                k = act[i] ? int'(($time - st[i]) / 10) : 0;
                if (act[i] && k < flen(i) * C) begin
                    et = fbit(i, mb[i], k / C); er = 1'b0;
                end else begin
                    act[i] = 1'b0; et = 1'b1; er = 1'b1;
                end
                chk($sformatf("tx[%0d]", i),    int'(tx[i]),    int'(et));
                chk($sformatf("ready[%0d]", i), int'(ready[i]), int'(er));
                chk($sformatf("busy[%0d]", i),  int'(busy[i]),  int'(!er));
                mrdy[i] = er;
            end
        end
    end

    // Caller is at a negedge; returns at the negedge where ready is back (or after an abort)
    task automatic run_frame(input int idx, input logic [7:0] b, input bit keep_valid,
                             input int pulse_at, input int rst_at,
                             output logic [11:0] bits, output int lat, output time acc_t);
        int n, g;
        bits = '0; lat = 0;
        g = 0;
        while (!ready[idx] && g < 200) begin @(negedge clk); g++; end
        chk("ready_wait", int'(ready[idx]), 1);
        data[idx] = b; valid[idx] = 1'b1;
        @(posedge clk);
        acc_t = $time;
        for (n = 0; n < flen(idx) * C; n++) begin
            @(negedge clk);
            if (n == 0 && !keep_valid) valid[idx] = 1'b0;
            if (pulse_at >= 0 && n == pulse_at) begin data[idx] = ~b; valid[idx] = 1'b1; end
            if (pulse_at >= 0 && n == pulse_at + 1) valid[idx] = 1'b0;
            if (rst_at >= 0 && n == rst_at) rst = 1'b1;
            if (rst_at >= 0 && n == rst_at + 1) begin
                chk("abort_tx",    int'(tx[idx]),    1);
                chk("abort_ready", int'(ready[idx]), 1);
                chk("abort_busy",  int'(busy[idx]),  0);
                rst = 1'b0;
                return;
            end
            if (n % C == C / 2) bits[n / C] = tx[idx];
        end
        n = flen(idx) * C - 1; g = 0;
        while (!ready[idx] && g < 200) begin @(negedge clk); n++; g++; end
        lat = n;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] bits;
        int          lat, idx, prev_idx;
        time         t0, t1, t2;
        logic [7:0]  b0, b1, b2, rb;
        bit          kv;

        rst = 1'b1; valid[0] = 1'b1; data[0] = 8'hC3;
        repeat (5) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_tx",    int'(tx[0]),    1);
        chk("rst_ready", int'(ready[0]), 1);
        chk("rst_busy",  int'(busy[0]),  0);
        @(negedge clk);
        chk("rst_noacc_tx", int'(tx[0]), 1);
        valid[0] = 1'b0; rst = 1'b0;
        @(negedge clk);

        run_frame(0, 8'hA5, 1'b0, -1, -1, bits, lat, t0);
        chk("a5_bits", int'(bits[9:0]), int'(10'b1101001010));
        chk("a5_ready_lat", lat, 40);

        run_frame(0, 8'h00, 1'b1, -1, -1, bits, lat, t0); b0 = bits[8:1];
        run_frame(0, 8'hFF, 1'b1, -1, -1, bits, lat, t1); b1 = bits[8:1];
        run_frame(0, 8'h3C, 1'b1, -1, -1, bits, lat, t2); b2 = bits[8:1];
        valid[0] = 1'b0;
        chk("b2b_byte0", int'(b0), 'h00);
        chk("b2b_byte1", int'(b1), 'hFF);
        chk("b2b_byte2", int'(b2), 'h3C);
        chk("b2b_gap01", int'((t1 - t0) / 10), 41);
        chk("b2b_gap12", int'((t2 - t1) / 10), 41);

        run_frame(1, 8'h07, 1'b0, -1, -1, bits, lat, t0);
        chk("par_even_bit", int'(bits[9]), 1);
        chk("par_even_stop", int'(bits[10]), 1);
        chk("par_even_byte", int'(bits[8:1]), 'h07);
        chk("par_even_lat", lat, 44);
        run_frame(2, 8'h07, 1'b0, -1, -1, bits, lat, t0);
        chk("par_odd_bit", int'(bits[9]), 0);
        chk("par_odd_lat", lat, 44);

        run_frame(3, 8'h81, 1'b0, 20, -1, bits, lat, t0);
        chk("stop2_byte", int'(bits[8:1]), 'h81);
        chk("stop2_bits", int'(bits[10:9]), 3);
        chk("stop2_lat", lat, 44);

        run_frame(0, 8'hF0, 1'b0, -1, 17, bits, lat, t0);
        run_frame(0, 8'h5A, 1'b0, -1, -1, bits, lat, t0);
        chk("post_rst_byte", int'(bits[8:1]), 'h5A);

        prev_idx = 0;
        repeat (24) begin
            idx = $urandom_range(0, N - 1);
            rb  = 8'($urandom);
            kv  = 1'($urandom_range(0, 1));
            if (idx != prev_idx) valid[prev_idx] = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                valid[idx] = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            run_frame(idx, rb, kv, -1, -1, bits, lat, t0);
            chk($sformatf("rand_byte[%0d]", idx), int'(bits[8:1]), int'(rb));
            prev_idx = idx;
        end
        for (int i = 0; i < N; i++) valid[i] = 1'b0;
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
